// File: rtl/iddmm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iddmm_pkg
// Purpose  : Shared types and constants for the IDDMM task driver:
//            controller state encoding, one-hot operand-RAM select codes and
//            default word geometry of the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package iddmm_pkg;

  // Default geometry; must match the attached multiplier instance.
  localparam int DEF_K = 256;
  localparam int DEF_N = 16;

  // One-hot write strobes into the multiplier operand RAMs.
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_X    = 3'b001;
  localparam logic [2:0] OP_Y    = 3'b010;
  localparam logic [2:0] OP_M    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_X  = 3'd1,
    ST_LOAD_Y  = 3'd2,
    ST_LOAD_M  = 3'd3,
    ST_REQ     = 3'd4,
    ST_WAIT    = 3'd5,
    ST_COLLECT = 3'd6,
    ST_DRAIN   = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/iddmm_res_buf.sv
`default_nettype none
// ============================================================================
// Module   : iddmm_res_buf
// Purpose  : N x K simple dual-port result buffer. One synchronous write port
//            filled while the multiplier returns its result burst, one
//            asynchronous read port addressed while the result is replayed.
// Ports    : clk      - system clock
//            wr_en    - write strobe
//            wr_addr  - write word index
//            wr_data  - write word
//            rd_addr  - read word index
//            rd_data  - read word (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module iddmm_res_buf
  import iddmm_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [K-1:0]      rd_data
);

  // Storage carries no reset: contents are always rewritten before use.
  logic [K-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/iddmm_task_driver.sv
`default_nettype none
// ============================================================================
// Module   : iddmm_task_driver
// Purpose  : Initiator-side front end for the IDDMM Montgomery multiplier.
//            Streams x, y, m operand words into the multiplier RAMs, issues a
//            task request, buffers the N-word result burst and replays it on
//            a backpressured output stream.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            s_valid/s_ready/s_data/s_m1 - operand word stream, m' constant
//            mm_wr_ena/addr/data/m1      - multiplier operand RAM write port
//            mm_task_req/grant           - start handshake
//            mm_task_end/res             - result word strobe and data
//            r_valid/r_ready/r_data/r_last - result stream
//            busy                        - controller not idle
// Option   : IDDMM_TASK_DRIVER_REUSE_M_EN adds cfg_reuse_m; when set at the
//            x[0] handshake and a modulus is already loaded, the m phase is
//            skipped and the stream carries only x and y.
// Revision : 1.0 - initial release
// ============================================================================
module iddmm_task_driver
  import iddmm_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [K-1:0]      s_data,
  input  logic [K-1:0]      s_m1,
  output logic [2:0]        mm_wr_ena,
  output logic [ADDR_W-1:0] mm_wr_addr,
  output logic [K-1:0]      mm_wr_data,
  output logic [K-1:0]      mm_wr_m1,
  output logic              mm_task_req,
  input  logic              mm_task_grant,
  input  logic              mm_task_end,
  input  logic [K-1:0]      mm_task_res,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [K-1:0]      r_data,
  output logic              r_last,
  output logic              busy
`ifdef IDDMM_TASK_DRIVER_REUSE_M_EN
  ,
  input  logic              cfg_reuse_m
`endif
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(N - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;
  logic              load_phase;
  logic              collect_phase;
  logic              drain_phase;
  logic [2:0]        op_sel;
  logic              s_fire;
  logic              res_fire;
  logic              r_fire;
  logic              skip_m;
  logic              m1_capture;
  logic [K-1:0]      buf_rd;

  assign cnt_last = (cnt == CNT_LAST);

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    load_phase    = 1'b0;
    collect_phase = 1'b0;
    drain_phase   = 1'b0;
    op_sel        = OP_NONE;
    case (state)
      ST_IDLE: begin
        // The first accepted word is x[0].
        load_phase = 1'b1;
        op_sel     = OP_X;
        if (s_valid) next_state = ST_LOAD_X;
      end
      ST_LOAD_X: begin
        load_phase = 1'b1;
        op_sel     = OP_X;
        if (s_valid && cnt_last) next_state = ST_LOAD_Y;
      end
      ST_LOAD_Y: begin
        load_phase = 1'b1;
        op_sel     = OP_Y;
        if (s_valid && cnt_last) next_state = skip_m ? ST_REQ : ST_LOAD_M;
      end
      ST_LOAD_M: begin
        load_phase = 1'b1;
        op_sel     = OP_M;
        if (s_valid && cnt_last) next_state = ST_REQ;
      end
      ST_REQ: begin
        if (mm_task_req && mm_task_grant) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        collect_phase = 1'b1;
        if (mm_task_end) next_state = cnt_last ? ST_DRAIN : ST_COLLECT;
      end
      ST_COLLECT: begin
        collect_phase = 1'b1;
        if (mm_task_end && cnt_last) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_phase = 1'b1;
        if (r_ready && cnt_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign s_fire   = s_valid & load_phase;
  assign res_fire = mm_task_end & collect_phase;
  assign r_fire   = r_ready & drain_phase;

  // Ready is gated by reset so that every output reads 0 while rst_n is low,
  // even though IDLE itself accepts words.
  assign s_ready  = load_phase & rst_n;
  assign busy     = (state != ST_IDLE);
  assign r_valid  = drain_phase;
  assign r_last   = drain_phase & cnt_last;
  assign r_data   = drain_phase ? buf_rd : '0;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mm_wr_ena   <= OP_NONE;
      mm_wr_addr  <= '0;
      mm_wr_data  <= '0;
      mm_wr_m1    <= '0;
      mm_task_req <= 1'b0;
    end else begin
      mm_wr_ena <= OP_NONE;
      if (s_fire) begin
        mm_wr_ena  <= op_sel;
        mm_wr_addr <= cnt;
        mm_wr_data <= s_data;
      end
      // Load, collect and drain phases are mutually exclusive, so one word
      // counter serves all three; it is always 0 on entry to each phase.
      if (s_fire || res_fire || r_fire) begin
        cnt <= cnt_last ? '0 : cnt + ADDR_W'(1);
      end
      if ((state == ST_IDLE) && s_fire && m1_capture) begin
        mm_wr_m1 <= s_m1;
      end
      // Request rises on the second REQ cycle (one cycle after the final
      // operand write is visible) and falls on the edge that samples grant.
      if (state == ST_REQ) begin
        mm_task_req <= ~(mm_task_req & mm_task_grant);
      end
    end
  end

`ifdef IDDMM_TASK_DRIVER_REUSE_M_EN
  logic reuse_q;
  logic m_loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reuse_q  <= 1'b0;
      m_loaded <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && s_fire) begin
        reuse_q <= cfg_reuse_m;
      end
      if ((state == ST_LOAD_M) && s_fire && cnt_last) begin
        m_loaded <= 1'b1;
      end
    end
  end

  assign skip_m     = reuse_q & m_loaded;
  // A reused modulus keeps its matching m' constant.
  assign m1_capture = ~(cfg_reuse_m & m_loaded);
`else
  assign skip_m     = 1'b0;
  assign m1_capture = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Result buffer
  // --------------------------------------------------------------------------
  iddmm_res_buf #(
    .K      (K),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_res_buf (
    .clk     (clk),
    .wr_en   (res_fire),
    .wr_addr (cnt),
    .wr_data (mm_task_res),
    .rd_addr (cnt),
    .rd_data (buf_rd)
  );

endmodule
`default_nettype wire

// File: tb/tb_iddmm_task_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_iddmm_task_driver
// Purpose  : Self-checking bench for iddmm_task_driver (K=8, N=4). Drives
//            operand jobs, models the multiplier handshake and result burst,
//            and checks writes, request timing and replayed results against
//            expectations derived from the job contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iddmm_task_driver;

  localparam int K  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [K-1:0]  s_data = '0;
  logic [K-1:0]  s_m1 = '0;
  logic [2:0]    mm_wr_ena;
  logic [AW-1:0] mm_wr_addr;
  logic [K-1:0]  mm_wr_data;
  logic [K-1:0]  mm_wr_m1;
  logic          mm_task_req;
  logic          mm_task_grant = 1'b0;
  logic          mm_task_end = 1'b0;
  logic [K-1:0]  mm_task_res = '0;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic [K-1:0]  r_data;
  logic          r_last;
  logic          busy;
`ifdef IDDMM_TASK_DRIVER_REUSE_M_EN
  logic          cfg_reuse_m = 1'b0;
`endif

  iddmm_task_driver #(
    .K      (K),
    .N      (N),
    .ADDR_W (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_m1          (s_m1),
    .mm_wr_ena     (mm_wr_ena),
    .mm_wr_addr    (mm_wr_addr),
    .mm_wr_data    (mm_wr_data),
    .mm_wr_m1      (mm_wr_m1),
    .mm_task_req   (mm_task_req),
    .mm_task_grant (mm_task_grant),
    .mm_task_end   (mm_task_end),
    .mm_task_res   (mm_task_res),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_data        (r_data),
    .r_last        (r_last),
    .busy          (busy)
`ifdef IDDMM_TASK_DRIVER_REUSE_M_EN
    ,
    .cfg_reuse_m   (cfg_reuse_m)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log of every operand-RAM write seen on the port, sampled mid-cycle.
  typedef struct {
    int            cyc;
    logic [2:0]    ena;
    logic [AW-1:0] addr;
    logic [K-1:0]  data;
  } wr_t;

  wr_t wr_q[$];
  wr_t mon_e;

  always @(negedge clk) begin
    if (rst_n && (mm_wr_ena != 3'b000)) begin
      mon_e.cyc  = cyc;
      mon_e.ena  = mm_wr_ena;
      mon_e.addr = mm_wr_addr;
      mon_e.data = mm_wr_data;
      wr_q.push_back(mon_e);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference state carried across jobs.
  bit           m_loaded_m = 1'b0;
  logic [K-1:0] m1_m = '0;

  int end_pat[6] = '{1, 0, 1, 1, 0, 1};
  int rdy_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic pulse_reset();
    s_valid       = 1'b0;
    mm_task_grant = 1'b0;
    mm_task_end   = 1'b0;
    r_ready       = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_s_ready",  s_ready, 0);
    check("rst_busy",     busy, 0);
    check("rst_wr_ena",   mm_wr_ena, 0);
    check("rst_wr_addr",  mm_wr_addr, 0);
    check("rst_wr_data",  mm_wr_data, 0);
    check("rst_wr_m1",    mm_wr_m1, 0);
    check("rst_task_req", mm_task_req, 0);
    check("rst_r_valid",  r_valid, 0);
    check("rst_r_data",   r_data, 0);
    check("rst_r_last",   r_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wr_q.delete();
    m_loaded_m = 1'b0;
    m1_m       = '0;
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_busy",    busy, 0);
  endtask

  // mode 0: fixed operands, no stalls; mode 1: test-plan gap/ready patterns;
  // mode 2: random operands, gaps, backpressure and stray task_end.
  // abort_after > 0 pulses reset after that many accepted words.
  task automatic run_job(input int mode, input int gdelay, input bit reuse, input int abort_after);
    logic [K-1:0] ops[3][N];
    logic [K-1:0] res[N];
    logic [K-1:0] m1;
    logic [2:0]   exp_ena;
    bit           skip;
    bit           rdy;
    int           nwords;
    int           t;
    int           p;
    int           k;
    int           j;

    for (int op = 0; op < 3; op++)
      for (int i = 0; i < N; i++)
        ops[op][i] = (mode == 0) ? K'(op * N + i + 1) : K'($urandom);
    for (int i = 0; i < N; i++) res[i] = K'($urandom);
    m1     = K'($urandom);
    skip   = reuse && m_loaded_m;
    nwords = skip ? 2 * N : 3 * N;
    wr_q.delete();

    // Operand stream
    for (int w = 0; w < nwords; w++) begin
      if (mode == 2) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          step();
        end
      end
      s_valid = 1'b1;
      s_data  = ops[w / N][w % N];
      if (w == 0) begin
        s_m1 = m1;
`ifdef IDDMM_TASK_DRIVER_REUSE_M_EN
        cfg_reuse_m = reuse;
`endif
      end else begin
        s_m1 = K'($urandom);
      end
      check("s_ready_load", s_ready, 1);
      step();
      if (abort_after == w + 1) begin
        pulse_reset();
        return;
      end
    end
    s_valid = 1'b0;

    // Request / grant
    t = 0;
    while (!mm_task_req && t < 10) begin
      step();
      t++;
    end
    if (!mm_task_req) begin
      check("req_timeout", 0, 1);
      pulse_reset();
      return;
    end
    if (wr_q.size() > 0) check("req_rise_latency", cyc - wr_q[wr_q.size() - 1].cyc, 1);
    else check("req_no_writes", 0, 1);
    check("s_ready_req", s_ready, 0);
    check("busy_req", busy, 1);
    for (int h = 1; h < gdelay; h++) begin
      step();
      check("req_hold", mm_task_req, 1);
    end
    mm_task_grant = 1'b1;
    step();
    mm_task_grant = 1'b0;
    check("req_drop", mm_task_req, 0);
    check("wr_m1", mm_wr_m1, skip ? m1_m : m1);
    if (!skip) m1_m = m1;

    // Result burst from the multiplier model
    p = 0;
    if (mode == 2) begin
      while ($urandom_range(0, 1) == 0) step();
    end
    for (int i = 0; i < N; i++) begin
      if (mode == 1) begin
        while (p < 6 && end_pat[p] == 0) begin
          mm_task_end = 1'b0;
          step();
          check("r_valid_early", r_valid, 0);
          p++;
        end
      end else if (mode == 2) begin
        while ($urandom_range(0, 2) == 0) begin
          mm_task_end = 1'b0;
          step();
          check("r_valid_early", r_valid, 0);
        end
      end
      mm_task_end = 1'b1;
      mm_task_res = res[i];
      step();
      p++;
      check("drain_entry", r_valid, (i == N - 1) ? 1 : 0);
    end
    mm_task_end = 1'b0;

    // Drain with backpressure
    k = 0;
    j = 0;
    t = 0;
    while (k < N && t < 40) begin
      check("r_valid", r_valid, 1);
      check("r_data", r_data, res[k]);
      check("r_last", r_last, (k == N - 1) ? 1 : 0);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (j < 7) ? (rdy_pat[j] != 0) : 1'b1;
      else rdy = ($urandom_range(0, 1) == 1);
      r_ready = rdy;
      if (mode == 2) begin
        mm_task_end = ($urandom_range(0, 1) == 1);
        mm_task_res = K'($urandom);
      end
      step();
      if (rdy) k++;
      j++;
      t++;
    end
    r_ready     = 1'b0;
    mm_task_end = 1'b0;
    check("drain_words", k, N);
    check("idle_busy", busy, 0);
    check("idle_r_valid", r_valid, 0);
    check("idle_s_ready", s_ready, 1);

    // Operand write log against the job contents
    check("wr_count", wr_q.size(), nwords);
    for (int w = 0; w < nwords && w < wr_q.size(); w++) begin
      exp_ena = 3'b001;
      exp_ena = exp_ena << (w / N);
      check("wr_entry", {wr_q[w].ena, wr_q[w].addr, wr_q[w].data},
            {exp_ena, AW'(w % N), ops[w / N][w % N]});
    end
    if (!skip) m_loaded_m = 1'b1;
  endtask

  initial begin
    pulse_reset();
    run_job(0, 1, 1'b0, -1);
    run_job(1, 5, 1'b0, -1);
    run_job(2, 1, 1'b0, N + 2);
    run_job(0, 2, 1'b0, -1);
    for (int r = 0; r < 4; r++) run_job(2, $urandom_range(1, 4), 1'b0, -1);
`ifdef IDDMM_TASK_DRIVER_REUSE_M_EN
    run_job(2, 2, 1'b0, -1);
    run_job(2, 3, 1'b1, -1);
    run_job(1, 1, 1'b1, -1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iddmm_task_driver.md
Name: iddmm_task_driver

Overview:
- Initiator-side front end for the IDDMM Montgomery multiplier.
- Accepts x, y and m operands as a K-bit word stream (valid/ready) and writes each word into the multiplier operand RAMs through the wr_ena/wr_addr port.
- Raises task_req and captures the N-word result burst into a local buffer.
- Replays the result to the consumer on a backpressured stream, so the multiplier never stalls.

Parameters:
- K, 256, bits per word; must match the multiplier.
- N, 16, words per operand; must match the multiplier.
- ADDR_W, $clog2(N), word address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  operand word valid
- s_ready  out  1  operand word accepted when s_valid & s_ready
- s_data  in  K  operand word; order is x[0..N-1], y[0..N-1], m[0..N-1], LSW first
- s_m1  in  K  Montgomery constant -m^-1 mod 2^K; sampled with the first x word
- mm_wr_ena  out  3  one-hot write strobe: bit0 = x, bit1 = y, bit2 = m
- mm_wr_addr  out  ADDR_W  word index
- mm_wr_data  out  K  drives wr_x, wr_y and wr_m together
- mm_wr_m1  out  K  registered copy of s_m1
- mm_task_req  out  1  start request
- mm_task_grant  in  1  multiplier accepted the request
- mm_task_end  in  1  result word valid
- mm_task_res  in  K  result word
- r_valid  out  1  result word valid
- r_ready  in  1  consumer ready
- r_data  out  K  result word, LSW first
- r_last  out  1  high on word N-1
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock, reset and multiplier-side ports follow the decided interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: every output 0; state IDLE; word counter 0.
- Reset mid-operation aborts immediately. The multiplier's memory contents are don't-care after reset.
- State machine: IDLE -> LOAD_X -> LOAD_Y -> LOAD_M -> REQ -> WAIT -> COLLECT -> DRAIN -> IDLE.
- IDLE
  - s_ready = 1.
  - The first s_valid handshake is x[0]: it moves to LOAD_X with counter = 1 and captures s_m1.
- LOAD_X / LOAD_Y / LOAD_M
  - s_ready = 1.
  - Each handshake registers mm_wr_ena (one-hot for the current operand), mm_wr_addr = counter and mm_wr_data = s_data. Write appears one cycle after the handshake, for one cycle.
  - No handshake means mm_wr_ena = 0.
  - Counter wraps N-1 -> 0 and advances the state.
- REQ
  - Entered one cycle after the last m write is issued.
  - mm_task_req held high until mm_task_grant is sampled high; deasserted on the next edge; go to WAIT.
  - A grant arriving in the same cycle req rises is valid.
- WAIT / COLLECT
  - Each cycle with mm_task_end = 1 writes mm_task_res into buffer[counter], counter + 1.
  - The first such cycle moves WAIT -> COLLECT.
  - The multiplier delivers exactly N words, not necessarily contiguous. After word N-1, go to DRAIN with counter = 0.
  - mm_task_end in any other state is ignored.
- DRAIN
  - r_valid = 1, r_data = buffer[counter], r_last = (counter == N-1).
  - Advance only on r_valid & r_ready.
  - r_data is stable while r_ready = 0.
  - After the last handshake, go to IDLE. The next job may begin the following cycle.
- s_ready = 0 in REQ, WAIT, COLLECT and DRAIN; no overlap between jobs.
- Minimum job latency from the first x word to the first r_valid: 3N + 2 + multiplier latency.

Optional Feature:
- Macro IDDMM_TASK_DRIVER_REUSE_M_EN.
- When defined:
  - Adds input cfg_reuse_m (sampled at the x[0] handshake) and internal flag m_loaded.
  - m_loaded is set after a full LOAD_M; cleared by reset.
  - If cfg_reuse_m = 1 and m_loaded = 1, LOAD_Y goes directly to REQ. The stream then carries only 2N words, and mm_wr_m1 keeps its previous value.
- When undefined: m is always loaded and the port is absent.

Decomposition:
- Package iddmm_pkg holds:
  - the state enum typedef
  - operand-select localparams (OP_X = 3'b001, OP_Y = 3'b010, OP_M = 3'b100)
  - default K/N constants
- One natural sub-module: iddmm_res_buf, an N x K simple dual-port result buffer (write from COLLECT, read address from DRAIN).

Test Plan:
- K=8, N=4, x = {1,2,3,4}, y = {5,6,7,8}, m = {9,10,11,12}, no stalls -> exactly 12 single-cycle writes with mm_wr_ena 001/010/100 and addr 0..3; task_req rises 1 cycle after the last m write.
- Grant delayed 5 cycles -> task_req stays high 5 cycles and drops the cycle after grant; then model returns {A0,A1,A2,A3} -> r_data A0..A3, r_last on A3.
- Result burst with gaps (task_end pattern 1,0,1,1,0,1) -> all 4 words captured in order; DRAIN entered after the 4th word.
- r_ready toggled 1,0,0,1,1,0,1 during DRAIN -> each word held stable until accepted; no loss or duplication; IDLE after r_last accepted.
- rst_n pulsed low during LOAD_Y (word 2) -> outputs 0 asynchronously; a fresh full job afterwards completes correctly.
- With IDDMM_TASK_DRIVER_REUSE_M_EN: job 1 with cfg_reuse_m = 0, job 2 with cfg_reuse_m = 1 -> job 2 has 8 stream words, no bit2 writes, correct result.
